// File: rtl/uart_line_monitor.sv
// Serial-line UART receiver/monitor: decodes rx at bit level, buffers characters
// in a first-word-fall-through FIFO and flags framing, parity, overflow and EOT.
`timescale 1ns/1ps
module uart_line_monitor #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter logic [7:0]  EOT_CHAR     = 8'h04
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overflow,
  output logic                          eot_seen,
  output logic [31:0]                   char_count
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BREAK} state_t;

  state_t               state, state_next;
  logic                 rx_meta, rxs;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 bad_par;
  logic                 bit_tick, load_half, load_full, shift_en, par_chk;
  logic                 frame_set, stop_good, par_exp;
  logic [7:0]           rx_byte;
  logic                 push_req, push, pop, full, ovf_set, par_set, eot_set;
  logic [AW:0]          wr_ptr, rd_ptr;
  logic [7:0]           mem [FIFO_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  assign bit_tick = (cnt == '0);

  always_comb begin
    state_next = state;
    load_half  = 1'b0;
    load_full  = 1'b0;
    shift_en   = 1'b0;
    par_chk    = 1'b0;
    frame_set  = 1'b0;
    stop_good  = 1'b0;
    case (state)
      IDLE:  if (!rxs) begin
               load_half  = 1'b1;
               state_next = START;
             end
      START: if (bit_tick) begin
               if (rxs) state_next = IDLE;
               else begin
                 load_full  = 1'b1;
                 state_next = DATA;
               end
             end
      DATA:  if (bit_tick) begin
               shift_en  = 1'b1;
               load_full = 1'b1;
               if (bit_idx == BW'(DATA_BITS - 1))
                 state_next = (PARITY != 0) ? PAR : STOP;
             end
      PAR:   if (bit_tick) begin
               par_chk    = 1'b1;
               load_full  = 1'b1;
               state_next = STOP;
             end
      STOP:  if (bit_tick) begin
               if (rxs) begin
                 stop_good  = 1'b1;
                 state_next = IDLE;
               end else begin
                 frame_set  = 1'b1;
                 state_next = BREAK;
               end
             end
      BREAK: if (rxs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign par_exp = (^shreg) ^ (PARITY == 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      bad_par <= 1'b0;
    end else begin
      if (load_half)      cnt <= CW'(CLKS_PER_BIT / 2 - 1);
      else if (load_full) cnt <= CW'(CLKS_PER_BIT - 1);
      else if (!bit_tick) cnt <= cnt - 1'b1;

      if (state == START) bit_idx <= '0;
      else if (shift_en)  bit_idx <= bit_idx + 1'b1;

      if (shift_en) shreg <= {rxs, shreg[DATA_BITS-1:1]};

      if (state == IDLE)                 bad_par <= 1'b0;
      else if (par_chk && rxs != par_exp) bad_par <= 1'b1;
    end
  end

  assign rx_byte  = 8'(shreg);
  assign push_req = stop_good && !bad_par;
  assign par_set  = stop_good && bad_par;
  assign rd_valid = (wr_ptr != rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = rd_en && rd_valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign eot_set  = push_req && (rx_byte == EOT_CHAR);

  assign fifo_count = wr_ptr - rd_ptr;
  assign rd_data    = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= rx_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      char_count <= '0;
    end else begin
      if (push)      wr_ptr     <= wr_ptr + 1'b1;
      if (pop)       rd_ptr     <= rd_ptr + 1'b1;
      if (stop_good) char_count <= char_count + 1'b1;
    end
  end

  // Set events win over a simultaneous clr_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overflow   <= 1'b0;
      eot_seen   <= 1'b0;
    end else begin
      if (frame_set)    frame_err  <= 1'b1;
      else if (clr_err) frame_err  <= 1'b0;
      if (par_set)      parity_err <= 1'b1;
      else if (clr_err) parity_err <= 1'b0;
      if (ovf_set)      overflow   <= 1'b1;
      else if (clr_err) overflow   <= 1'b0;
      if (eot_set)      eot_seen   <= 1'b1;
      else if (clr_err) eot_seen   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_line_monitor.sv
// Self-checking bench for uart_line_monitor: an 8N1 instance (depth 4) and an
// 8E1 instance (depth 16) driven with bit-level serial frames.
`timescale 1ns/1ps
module tb_uart_line_monitor;

  localparam int CPB = 16;

  logic clk, rst_n;
  logic rx_a, rd_en_a, clr_a;
  logic [7:0] rd_data_a;
  logic rd_valid_a, frame_err_a, parity_err_a, overflow_a, eot_a;
  logic [2:0] fifo_count_a;
  logic [31:0] char_count_a;

  logic rx_p, rd_en_p, clr_p;
  logic [7:0] rd_data_p;
  logic rd_valid_p, frame_err_p, parity_err_p, overflow_p, eot_p;
  logic [4:0] fifo_count_p;
  logic [31:0] char_count_p;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp_qp [$];
  logic exp_ovf;

  uart_line_monitor #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4),
                      .EOT_CHAR(8'h04)) u_dut (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .rd_en(rd_en_a), .clr_err(clr_a),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .fifo_count(fifo_count_a),
    .frame_err(frame_err_a), .parity_err(parity_err_a), .overflow(overflow_a),
    .eot_seen(eot_a), .char_count(char_count_a));

  uart_line_monitor #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(16),
                      .EOT_CHAR(8'h04)) u_par (
    .clk(clk), .rst_n(rst_n), .rx(rx_p), .rd_en(rd_en_p), .clr_err(clr_p),
    .rd_data(rd_data_p), .rd_valid(rd_valid_p), .fifo_count(fifo_count_p),
    .frame_err(frame_err_p), .parity_err(parity_err_p), .overflow(overflow_p),
    .eot_seen(eot_p), .char_count(char_count_p));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input bit sel, input logic v, input int n);
    if (sel) rx_p = v;
    else     rx_a = v;
    repeat (n) tick();
  endtask

  // pop_at_commit raises rd_en for exactly the cycle in which the stop bit is sampled.
  task automatic send_frame(input bit sel, input logic [7:0] d, input logic use_par,
                            input logic pbit, input logic stop_v, input bit pop_at_commit);
    drive_bit(sel, 1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i], CPB);
    if (use_par) drive_bit(sel, pbit, CPB);
    if (pop_at_commit) begin
      drive_bit(sel, stop_v, 10);
      rd_en_a = 1'b1;
      tick();
      rd_en_a = 1'b0;
      repeat (CPB - 11) tick();
    end else begin
      drive_bit(sel, stop_v, CPB);
    end
  endtask

  task automatic model_push_a(input logic [7:0] d);
    if (exp_q.size() < 4) exp_q.push_back(d);
    else                  exp_ovf = 1'b1;
  endtask

  task automatic read_one(input bit sel);
    @(negedge clk);
    if ((sel ? exp_qp.size() : exp_q.size()) == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL read_scoreboard: got a read with no expected byte queued, required one");
    end else if (sel) begin
      chk("rd_data_p", {24'd0, rd_data_p}, {24'd0, exp_qp.pop_front()});
    end else begin
      chk("rd_data_a", {24'd0, rd_data_a}, {24'd0, exp_q.pop_front()});
    end
    @(posedge clk);
    #1;
    if (sel) rd_en_p = 1'b1; else rd_en_a = 1'b1;
    tick();
    rd_en_p = 1'b0;
    rd_en_a = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [31:0] exp_cc;
  } basic_vec_t;

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic       exp_push;
  } par_vec_t;

  basic_vec_t bv [4];
  par_vec_t   pv [5];

  initial begin
    logic perr_model;

    bv[0] = '{8'h55, 32'd1};
    bv[1] = '{8'h00, 32'd2};
    bv[2] = '{8'hFF, 32'd3};
    bv[3] = '{8'hA3, 32'd4};
    pv[0] = '{8'h07, 1'b1, 1'b1};
    pv[1] = '{8'h07, 1'b0, 1'b0};
    pv[2] = '{8'h3C, 1'b0, 1'b1};
    pv[3] = '{8'h80, 1'b0, 1'b0};
    pv[4] = '{8'hFF, 1'b1, 1'b0};

    rx_a = 1'b1; rd_en_a = 1'b0; clr_a = 1'b0;
    rx_p = 1'b1; rd_en_p = 1'b0; clr_p = 1'b0;
    exp_ovf = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_valid", rd_valid_a, 0);
    chk("rst_rd_data", rd_data_a, 0);
    chk("rst_fifo_count", fifo_count_a, 0);
    chk("rst_flags", {frame_err_a, parity_err_a, overflow_a, eot_a}, 0);
    chk("rst_char_count", char_count_a, 0);
    chk("rst_char_count_p", char_count_p, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) tick();

    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(bv[i].data);
      send_frame(0, bv[i].data, 1'b0, 1'b0, 1'b1, 0);
      @(negedge clk);
      chk("basic_char_count", char_count_a, bv[i].exp_cc);
      chk("basic_rd_valid", rd_valid_a, 1);
      chk("basic_fifo_count", fifo_count_a, 1);
      chk("basic_flags", {frame_err_a, parity_err_a, overflow_a, eot_a}, 0);
      read_one(0);
      @(negedge clk);
      chk("basic_after_pop_count", fifo_count_a, 0);
      chk("basic_after_pop_valid", rd_valid_a, 0);
    end

    rx_a = 1'b0;
    repeat (4) tick();
    rx_a = 1'b1;
    repeat (3 * CPB) tick();
    @(negedge clk);
    chk("glitch_fifo_count", fifo_count_a, 0);
    chk("glitch_char_count", char_count_a, 4);
    chk("glitch_frame_err", frame_err_a, 0);

    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0, 0);
    drive_bit(0, 1'b0, 40 * CPB);
    @(negedge clk);
    chk("ferr_frame_err", frame_err_a, 1);
    chk("ferr_fifo_count", fifo_count_a, 0);
    chk("ferr_char_count", char_count_a, 4);
    drive_bit(0, 1'b1, 2 * CPB);
    exp_q.push_back(8'h31);
    send_frame(0, 8'h31, 1'b0, 1'b0, 1'b1, 0);
    @(negedge clk);
    chk("after_break_char_count", char_count_a, 5);
    read_one(0);
    pulse_clr();
    @(negedge clk);
    chk("clr_frame_err", frame_err_a, 0);

    for (int i = 0; i < 5; i++) begin
      model_push_a(8'h10 + 8'(i));
      send_frame(0, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b1, 0);
    end
    @(negedge clk);
    chk("ovf_fifo_count", fifo_count_a, 4);
    chk("ovf_flag", overflow_a, exp_ovf);
    chk("ovf_char_count", char_count_a, 10);
    repeat (4) read_one(0);
    @(negedge clk);
    chk("ovf_drained", fifo_count_a, 0);
    pulse_clr();
    exp_ovf = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", overflow_a, 0);

    for (int i = 0; i < 4; i++) begin
      model_push_a(8'h20 + 8'(i));
      send_frame(0, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b1, 0);
    end
    @(negedge clk);
    chk("full_fifo_count", fifo_count_a, 4);
    chk("full_head", rd_data_a, exp_q[0]);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h24);
    tick();
    send_frame(0, 8'h24, 1'b0, 1'b0, 1'b1, 1);
    @(negedge clk);
    chk("pop_push_overflow", overflow_a, 0);
    chk("pop_push_fifo_count", fifo_count_a, 4);
    chk("pop_push_char_count", char_count_a, 15);
    repeat (4) read_one(0);

    rd_en_a = 1'b1;
    for (int i = 0; i < 5; i++) send_frame(0, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b1, 0);
    rd_en_a = 1'b0;
    tick();
    @(negedge clk);
    chk("held_rd_overflow", overflow_a, 0);
    chk("held_rd_fifo_count", fifo_count_a, 0);
    chk("held_rd_char_count", char_count_a, 20);

    exp_q.push_back(8'h4F);
    send_frame(0, 8'h4F, 1'b0, 1'b0, 1'b1, 0);
    @(negedge clk);
    chk("eot_after_O", eot_a, 0);
    exp_q.push_back(8'h4B);
    send_frame(0, 8'h4B, 1'b0, 1'b0, 1'b1, 0);
    @(negedge clk);
    chk("eot_after_K", eot_a, 0);
    exp_q.push_back(8'h04);
    send_frame(0, 8'h04, 1'b0, 1'b0, 1'b1, 0);
    @(negedge clk);
    chk("eot_seen", eot_a, 1);
    chk("eot_fifo_count", fifo_count_a, 3);
    chk("eot_char_count", char_count_a, 23);
    chk("eot_head", rd_data_a, exp_q[0]);
    tick();
    pulse_clr();
    @(negedge clk);
    chk("clr_all_flags", {frame_err_a, parity_err_a, overflow_a, eot_a}, 0);
    repeat (3) read_one(0);

    perr_model = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (pv[i].exp_push) exp_qp.push_back(pv[i].data);
      else                perr_model = 1'b1;
      send_frame(1, pv[i].data, 1'b1, pv[i].pbit, 1'b1, 0);
      @(negedge clk);
      chk("par_char_count", char_count_p, 32'(i + 1));
      chk("par_parity_err", parity_err_p, perr_model);
      chk("par_fifo_count", fifo_count_p, 32'(exp_qp.size()));
      chk("par_frame_err", frame_err_p, 0);
    end
    repeat (2) read_one(1);

    exp_q.push_back(8'h77);
    send_frame(0, 8'h77, 1'b0, 1'b0, 1'b1, 0);
    send_frame(0, 8'h12, 1'b0, 1'b0, 1'b0, 0);
    drive_bit(0, 1'b0, CPB);
    drive_bit(0, 1'b1, 2 * CPB);
    @(negedge clk);
    chk("pre_rst_frame_err", frame_err_a, 1);
    chk("pre_rst_fifo_count", fifo_count_a, 1);
    tick();
    drive_bit(0, 1'b0, CPB);
    drive_bit(0, 1'b1, CPB / 2);
    rst_n = 1'b0;
    exp_q.delete();
    exp_qp.delete();
    @(negedge clk);
    chk("midrst_rd_valid", rd_valid_a, 0);
    chk("midrst_rd_data", rd_data_a, 0);
    chk("midrst_fifo_count", fifo_count_a, 0);
    chk("midrst_flags", {frame_err_a, parity_err_a, overflow_a, eot_a}, 0);
    chk("midrst_char_count", char_count_a, 0);
    chk("midrst_char_count_p", char_count_p, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    drive_bit(0, 1'b1, 2 * CPB);
    exp_q.push_back(8'h3C);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 0);
    @(negedge clk);
    chk("post_rst_char_count", char_count_a, 1);
    chk("post_rst_flags", {frame_err_a, parity_err_a, overflow_a, eot_a}, 0);
    read_one(0);
    @(negedge clk);
    chk("post_rst_drained", fifo_count_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
